// File: rtl/cpu_defs_pkg.sv
// Shared opcode, state and control-code definitions for the multicycle CPU.
// The register file, ALU and datapath top decode the same codes.
package cpu_defs_pkg;

   localparam logic [5:0]
      OP_ADD  = 6'b000000, OP_SUB  = 6'b000001, OP_ADDIU = 6'b000010,
      OP_AND  = 6'b010000, OP_ANDI = 6'b010001, OP_ORI   = 6'b010010, OP_XORI = 6'b010011,
      OP_SLL  = 6'b011000, OP_SLTI = 6'b100110, OP_SLT   = 6'b100111,
      OP_SW   = 6'b110000, OP_LW   = 6'b110001,
      OP_BEQ  = 6'b110100, OP_BNE  = 6'b110101, OP_BLTZ  = 6'b110110,
      OP_J    = 6'b111000, OP_JR   = 6'b111001, OP_JAL   = 6'b111010,
      OP_HALT = 6'b111111;

   typedef enum logic [2:0] {
      S_IF     = 3'b000,
      S_ID     = 3'b001,
      S_EXE_LS = 3'b010,
      S_MEM    = 3'b011,
      S_WB_LD  = 3'b100,
      S_EXE_BR = 3'b101,
      S_EXE_AL = 3'b110,
      S_WB_AL  = 3'b111
   } state_t;

   localparam logic [2:0]
      ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_SLL = 3'b010, ALU_OR  = 3'b011,
      ALU_AND = 3'b100, ALU_SLTU = 3'b101, ALU_SLT = 3'b110, ALU_XOR = 3'b111;

   localparam logic [1:0] PC_NEXT = 2'b00, PC_BRANCH = 2'b01, PC_RS = 2'b10, PC_JUMP = 2'b11;
   localparam logic [1:0] RD_RA = 2'b00, RD_RT = 2'b01, RD_RD = 2'b10;

   typedef struct packed {
      logic       pc_wre;
      logic       ir_wre;
      logic       ins_mem_rw;
      logic       ext_sel;
      logic       alu_src_a;
      logic       alu_src_b;
      logic [2:0] alu_op;
      logic       m_rd;
      logic       m_wr;
      logic       db_data_src;
      logic       reg_wre;
      logic [1:0] reg_dst;
      logic       wr_reg_d_src;
      logic [1:0] pc_src;
   } ctrl_t;

   function automatic logic is_alu_imm(input logic [5:0] op);
      return op inside {OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI};
   endfunction

   function automatic logic is_alu(input logic [5:0] op);
      return is_alu_imm(op) || (op inside {OP_ADD, OP_SUB, OP_AND, OP_SLL, OP_SLT});
   endfunction

   function automatic logic is_branch(input logic [5:0] op);
      return op inside {OP_BEQ, OP_BNE, OP_BLTZ};
   endfunction

   // Unknown opcodes retire in ID exactly like a jump without a PC change.
   function automatic logic is_ends_in_id(input logic [5:0] op);
      return !(is_alu(op) || is_branch(op) || op inside {OP_LW, OP_SW, OP_HALT});
   endfunction

   function automatic logic [2:0] alu_op_of(input logic [5:0] op);
      case (op)
         OP_SUB, OP_BEQ, OP_BNE, OP_BLTZ: return ALU_SUB;
         OP_SLL:                          return ALU_SLL;
         OP_ORI:                          return ALU_OR;
         OP_AND, OP_ANDI:                 return ALU_AND;
         OP_SLT, OP_SLTI:                 return ALU_SLT;
         OP_XORI:                         return ALU_XOR;
         default:                         return ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control-unit <-> datapath bundle: IR/ALU flags in, strobes and debug state out.
interface multicycle_control_unit_if #(parameter int CNT_W = 32);
   logic [5:0]       opcode;
   logic             zero, sign;
   logic             PCWre, IRWre, InsMemRW, ExtSel, ALUSrcA, ALUSrcB;
   logic [2:0]       ALUOp;
   logic             mRD, mWR, DBDataSrc, RegWre, WrRegDSrc;
   logic [1:0]       RegDst, PCSrc;
   logic [2:0]       state;
   logic [CNT_W-1:0] instr_count;

   modport master (
      input  opcode, zero, sign,
      output PCWre, IRWre, InsMemRW, ExtSel, ALUSrcA, ALUSrcB, ALUOp,
             mRD, mWR, DBDataSrc, RegWre, RegDst, WrRegDSrc, PCSrc, state, instr_count
   );

   modport slave (
      output opcode, zero, sign,
      input  PCWre, IRWre, InsMemRW, ExtSel, ALUSrcA, ALUSrcB, ALUOp,
             mRD, mWR, DBDataSrc, RegWre, RegDst, WrRegDSrc, PCSrc, state, instr_count
   );
endinterface

// File: rtl/control_decode.sv
// Combinational control word from (state, opcode, zero, sign).
module control_decode
   import cpu_defs_pkg::*;
(
   input  state_t     state,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       sign,
   output ctrl_t      cw
);
   logic taken;

   always_comb begin
      cw    = '0;
      taken = (opcode == OP_BEQ && zero) || (opcode == OP_BNE && !zero) ||
              (opcode == OP_BLTZ && sign);

      // IF only fetches; the IR still holds the previous opcode there.
      if (state == S_IF) begin
         cw.ins_mem_rw = 1'b1;
         cw.ir_wre     = 1'b1;
      end else begin
         cw.ext_sel   = is_branch(opcode) || (opcode inside {OP_ADDIU, OP_SLTI, OP_LW, OP_SW});
         cw.alu_src_b = is_alu_imm(opcode) || (opcode inside {OP_LW, OP_SW});
         cw.alu_src_a = (opcode == OP_SLL);
         cw.alu_op    = alu_op_of(opcode);
      end

      case (state)
         S_ID: begin
            cw.pc_wre = is_ends_in_id(opcode);
            if (opcode inside {OP_J, OP_JAL}) cw.pc_src = PC_JUMP;
            else if (opcode == OP_JR)         cw.pc_src = PC_RS;
            if (opcode == OP_JAL) begin
               cw.reg_wre = 1'b1;
               cw.reg_dst = RD_RA;
            end
         end
         S_EXE_BR: begin
            cw.pc_wre = 1'b1;
            cw.pc_src = taken ? PC_BRANCH : PC_NEXT;
         end
         S_MEM: begin
            cw.m_rd        = (opcode == OP_LW);
            cw.m_wr        = (opcode == OP_SW);
            cw.db_data_src = (opcode == OP_LW);
            cw.pc_wre      = (opcode == OP_SW);
         end
         S_WB_LD: begin
            cw.pc_wre       = 1'b1;
            cw.reg_wre      = 1'b1;
            cw.reg_dst      = RD_RT;
            cw.wr_reg_d_src = 1'b1;
            cw.db_data_src  = (opcode == OP_LW);
         end
         S_WB_AL: begin
            cw.pc_wre       = 1'b1;
            cw.reg_wre      = 1'b1;
            cw.reg_dst      = is_alu_imm(opcode) ? RD_RT : RD_RD;
            cw.wr_reg_d_src = 1'b1;
         end
         default: ;
      endcase
   end
endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle IF/ID/EXE/MEM/WB sequencer: state register, next-state logic
// and retired-instruction counter around the combinational decoder.
module multicycle_control_unit
   import cpu_defs_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input logic                 CLK,
   input logic                 Reset,
   multicycle_control_unit_if.master bus
);
   state_t           st;
   ctrl_t            cw;
   logic [CNT_W-1:0] cnt;

   control_decode u_dec (
      .state (st),
      .opcode(bus.opcode),
      .zero  (bus.zero),
      .sign  (bus.sign),
      .cw    (cw)
   );

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         st  <= S_IF;
         cnt <= '0;
      end else begin
         if (cw.pc_wre) cnt <= cnt + CNT_W'(1);
         case (st)
            S_IF: st <= S_ID;
            S_ID: begin
               // halt parks in ID with PCWre low until Reset
               if (bus.opcode == OP_HALT)               st <= S_ID;
               else if (is_branch(bus.opcode))          st <= S_EXE_BR;
               else if (bus.opcode inside {OP_LW, OP_SW}) st <= S_EXE_LS;
               else if (is_alu(bus.opcode))             st <= S_EXE_AL;
               else                                     st <= S_IF;
            end
            S_EXE_LS: st <= S_MEM;
            S_MEM:    st <= (bus.opcode == OP_LW) ? S_WB_LD : S_IF;
            S_EXE_AL: st <= S_WB_AL;
            default:  st <= S_IF;
         endcase
      end
   end

   assign bus.PCWre       = cw.pc_wre;
   assign bus.IRWre       = cw.ir_wre;
   assign bus.InsMemRW    = cw.ins_mem_rw;
   assign bus.ExtSel      = cw.ext_sel;
   assign bus.ALUSrcA     = cw.alu_src_a;
   assign bus.ALUSrcB     = cw.alu_src_b;
   assign bus.ALUOp       = cw.alu_op;
   assign bus.mRD         = cw.m_rd;
   assign bus.mWR         = cw.m_wr;
   assign bus.DBDataSrc   = cw.db_data_src;
   assign bus.RegWre      = cw.reg_wre;
   assign bus.RegDst      = cw.reg_dst;
   assign bus.WrRegDSrc   = cw.wr_reg_d_src;
   assign bus.PCSrc       = cw.pc_src;
   assign bus.state       = st;
   assign bus.instr_count = cnt;
endmodule
